// File: rtl/ad9231_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ad9231_cfg_sequencer
// Function : Power-up configurator for two AD9231 ADCs on one shared 24-bit
//            SPI master. Writes each table entry to each chip, reads it back,
//            retries on mismatch, then grants single host SPI transactions.
// Revision : 1.0 - initial release
// ============================================================================
module ad9231_cfg_sequencer #(
  parameter int N_REGS    = 3,
  parameter int N_CHIPS   = 2,
  parameter int PWRUP_DLY = 5000,
  parameter int GAP_DLY   = 5000,
  parameter int DONE_TMO  = 4096,
  parameter int MAX_RETRY = 2
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        cfg_restart,
  output logic [7:0]  table_addr,
  input  logic [23:0] table_data,
  output logic        spi_start,
  output logic [23:0] spi_tdat,
  input  logic        spi_done,
  input  logic [7:0]  spi_rdata,
  output logic        chip_sel,
  input  logic        host_req,
  input  logic [23:0] host_tdat,
  output logic        host_ack,
  output logic        host_done,
  output logic [7:0]  host_rdata,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic [1:0]  cfg_err,
  output logic [12:0] err_addr
);

  localparam int c_CNT_MAX = (PWRUP_DLY > GAP_DLY) ? PWRUP_DLY : GAP_DLY;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
  localparam int c_TMO_W   = $clog2(DONE_TMO + 1);
  localparam int c_RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  // The WR state itself costs one cycle, so the power-up count stops two
  // short to land spi_start exactly PWRUP_DLY cycles after reset release.
  localparam logic [c_CNT_W-1:0] c_PWRUP_LAST = c_CNT_W'(PWRUP_DLY - 2);
  localparam logic [c_CNT_W-1:0] c_GAP_LAST   = c_CNT_W'(GAP_DLY - 1);
  localparam logic [c_TMO_W-1:0] c_TMO_LAST   = c_TMO_W'(DONE_TMO - 1);
  localparam logic [c_RTY_W-1:0] c_RTY_MAX    = c_RTY_W'(MAX_RETRY);
  localparam logic [7:0]         c_LAST_REG   = 8'(N_REGS - 1);
  localparam logic               c_LAST_CHIP  = 1'(N_CHIPS - 1);
  // Transfer register self-clears, so reading it back can never match.
  localparam logic [12:0]        c_XFER_REG   = 13'h0FF;

  typedef enum logic [3:0] {
    S_PWRUP   = 4'd0,
    S_WR      = 4'd1,
    S_WR_WAIT = 4'd2,
    S_GAP_W   = 4'd3,
    S_RD      = 4'd4,
    S_RD_WAIT = 4'd5,
    S_CHK     = 4'd6,
    S_NEXT    = 4'd7,
    S_READY   = 4'd8,
    S_H_WAIT  = 4'd9,
    S_H_GAP   = 4'd10,
    S_ERR     = 4'd11
  } state_t;

  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_TMO_W-1:0] r_tmo;
  logic [c_RTY_W-1:0] r_retry;
  logic [7:0]         r_rdata;
  logic               r_done_meta;
  logic               r_done_sync;
  logic               r_done_prev;

  logic               w_done_evt;
  logic [12:0]        w_tbl_reg;
  logic [7:0]         w_tbl_val;
  logic               w_gap_end;
  logic               w_tmo_end;
  logic               w_unused_bits;

  assign w_done_evt    = r_done_sync & ~r_done_prev;
  assign w_tbl_reg     = table_data[20:8];
  assign w_tbl_val     = table_data[7:0];
  assign w_gap_end     = (r_cnt >= c_GAP_LAST);
  assign w_tmo_end     = (r_tmo >= c_TMO_LAST);
  assign w_unused_bits = &{1'b0, table_data[23:21]};

  // Bring the asynchronous master done level into clk and keep one more stage for edge detection.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_done_meta <= 1'b0;
      r_done_sync <= 1'b0;
      r_done_prev <= 1'b0;
    end else begin
      r_done_meta <= spi_done;
      r_done_sync <= r_done_meta;
      r_done_prev <= r_done_sync;
    end
  end

  // Sequencer: power-up wait, write/verify per entry and chip, then host pass-through.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state    <= S_PWRUP;
      r_cnt      <= '0;
      r_tmo      <= '0;
      r_retry    <= '0;
      r_rdata    <= 8'h00;
      table_addr <= 8'h00;
      chip_sel   <= 1'b0;
      spi_start  <= 1'b0;
      spi_tdat   <= 24'hFFFFFF;
      host_ack   <= 1'b0;
      host_done  <= 1'b0;
      host_rdata <= 8'h00;
      cfg_busy   <= 1'b1;
      cfg_done   <= 1'b0;
      cfg_err    <= 2'd0;
      err_addr   <= 13'h0000;
    end else begin
      spi_start <= 1'b0;
      host_ack  <= 1'b0;
      host_done <= 1'b0;
      if (cfg_restart) begin
        // Restart wins over everything, including a same-cycle host_req.
        r_state    <= S_PWRUP;
        r_cnt      <= '0;
        r_tmo      <= '0;
        r_retry    <= '0;
        table_addr <= 8'h00;
        chip_sel   <= 1'b0;
        cfg_busy   <= 1'b1;
        cfg_done   <= 1'b0;
        cfg_err    <= 2'd0;
        err_addr   <= 13'h0000;
      end else begin
        unique case (r_state)
          S_PWRUP: begin
            if (r_cnt >= c_PWRUP_LAST) begin
              r_cnt   <= '0;
              r_state <= S_WR;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_WR: begin
            spi_tdat  <= table_data;
            spi_start <= 1'b1;
            r_tmo     <= '0;
            r_state   <= S_WR_WAIT;
          end
          S_WR_WAIT: begin
            if (w_done_evt) begin
              r_cnt   <= '0;
              r_state <= S_GAP_W;
            end else if (w_tmo_end) begin
              cfg_err  <= 2'd2;
              cfg_busy <= 1'b0;
              r_state  <= S_ERR;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
          end
          S_GAP_W: begin
            if (w_gap_end) begin
              r_cnt   <= '0;
              r_state <= (w_tbl_reg == c_XFER_REG) ? S_NEXT : S_RD;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_RD: begin
            spi_tdat  <= {1'b1, 2'b00, w_tbl_reg, 8'h00};
            spi_start <= 1'b1;
            r_tmo     <= '0;
            r_state   <= S_RD_WAIT;
          end
          S_RD_WAIT: begin
            if (w_done_evt) begin
              r_rdata <= spi_rdata;
              r_cnt   <= '0;
              r_state <= S_CHK;
            end else if (w_tmo_end) begin
              cfg_err  <= 2'd2;
              cfg_busy <= 1'b0;
              r_state  <= S_ERR;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
          end
          S_CHK: begin
            if (w_gap_end) begin
              r_cnt <= '0;
              if (r_rdata == w_tbl_val) begin
                r_state <= S_NEXT;
              end else if (r_retry < c_RTY_MAX) begin
                r_retry <= r_retry + 1'b1;
                r_state <= S_WR;
              end else begin
                cfg_err  <= 2'd1;
                err_addr <= w_tbl_reg;
                cfg_busy <= 1'b0;
                r_state  <= S_ERR;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_NEXT: begin
            r_retry <= '0;
            if (table_addr < c_LAST_REG) begin
              table_addr <= table_addr + 1'b1;
              r_state    <= S_WR;
            end else if (chip_sel < c_LAST_CHIP) begin
              chip_sel   <= chip_sel + 1'b1;
              table_addr <= 8'h00;
              r_state    <= S_WR;
            end else begin
              cfg_done <= 1'b1;
              cfg_busy <= 1'b0;
              r_state  <= S_READY;
            end
          end
          S_READY: begin
            if (host_req) begin
              host_ack  <= 1'b1;
              spi_start <= 1'b1;
              spi_tdat  <= host_tdat;
              r_tmo     <= '0;
              r_state   <= S_H_WAIT;
            end
          end
          S_H_WAIT: begin
            if (w_done_evt) begin
              host_rdata <= spi_rdata;
              host_done  <= 1'b1;
              r_cnt      <= '0;
              r_state    <= S_H_GAP;
            end else if (w_tmo_end) begin
              cfg_err <= 2'd2;
              r_state <= S_READY;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
          end
          S_H_GAP: begin
            if (w_gap_end) begin
              r_cnt   <= '0;
              r_state <= S_READY;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_ERR: begin
            r_state <= S_ERR;
          end
          default: begin
            r_state <= S_PWRUP;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ad9231_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ad9231_cfg_sequencer
// Function : Self-checking bench for ad9231_cfg_sequencer with an echoing
//            SPI slave model and a table-derived expected transaction list.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ad9231_cfg_sequencer;

  localparam int N_REGS    = 3;
  localparam int N_CHIPS   = 2;
  localparam int PWRUP_DLY = 40;
  localparam int GAP_DLY   = 12;
  localparam int DONE_TMO  = 64;
  localparam int MAX_RETRY = 2;

  logic        clk = 1'b0;
  logic        rstb = 1'b1;
  logic        cfg_restart = 1'b0;
  logic [7:0]  table_addr;
  logic [23:0] table_data;
  logic        spi_start;
  logic [23:0] spi_tdat;
  logic        spi_done = 1'b0;
  logic [7:0]  spi_rdata = 8'h00;
  logic        chip_sel;
  logic        host_req = 1'b0;
  logic [23:0] host_tdat = 24'h0;
  logic        host_ack;
  logic        host_done;
  logic [7:0]  host_rdata;
  logic        cfg_busy;
  logic        cfg_done;
  logic [1:0]  cfg_err;
  logic [12:0] err_addr;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t0 = 0;
  int n_ack = 0;

  // Table contents: register addresses fixed, data bytes randomized per run.
  logic [12:0] reg_addr [N_REGS];
  logic [7:0]  reg_val  [N_REGS];

  // Slave model state
  logic [7:0]  mem [2][256];
  int          lat = 4;
  bit          stall_all = 1'b0;
  bit          bad14 = 1'b0;
  logic [24:0] obs_q [$];   // {chip_sel, word} as seen on each spi_start
  logic [24:0] exp_q [$];
  int          exp_reads;

  ad9231_cfg_sequencer #(
    .N_REGS(N_REGS), .N_CHIPS(N_CHIPS), .PWRUP_DLY(PWRUP_DLY),
    .GAP_DLY(GAP_DLY), .DONE_TMO(DONE_TMO), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rstb(rstb), .cfg_restart(cfg_restart),
    .table_addr(table_addr), .table_data(table_data),
    .spi_start(spi_start), .spi_tdat(spi_tdat), .spi_done(spi_done),
    .spi_rdata(spi_rdata), .chip_sel(chip_sel),
    .host_req(host_req), .host_tdat(host_tdat), .host_ack(host_ack),
    .host_done(host_done), .host_rdata(host_rdata),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .err_addr(err_addr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (host_ack) n_ack <= n_ack + 1;

  always_comb begin
    table_data = 24'h000000;
    if (table_addr < 8'(N_REGS))
      table_data = {3'b000, reg_addr[table_addr[1:0]], reg_val[table_addr[1:0]]};
  end

  // SPI slave: logs every started word, echoes register memory on reads.
  initial begin : slave
    logic [23:0] w;
    logic        cs;
    forever begin
      @(negedge clk);
      if (rstb && spi_start) begin
        w  = spi_tdat;
        cs = chip_sel;
        obs_q.push_back({cs, w});
        if (!stall_all) begin
          if (!w[23]) mem[cs][w[15:8]] = w[7:0];
          repeat (lat) @(negedge clk);
          spi_rdata = (bad14 && !cs && w[20:8] == 13'h014) ? 8'h00 : mem[cs][w[15:8]];
          spi_done = 1'b1;
          repeat (3) @(negedge clk);
          spi_done = 1'b0;
        end
      end
    end
  end

  // Expected configuration traffic derived from the table alone.
  function automatic void build_expected();
    exp_q.delete();
    exp_reads = 0;
    for (int c = 0; c < N_CHIPS; c++)
      for (int i = 0; i < N_REGS; i++) begin
        exp_q.push_back({1'(c), 3'b000, reg_addr[i], reg_val[i]});
        if (reg_addr[i] != 13'h0FF) begin
          exp_q.push_back({1'(c), 3'b100, reg_addr[i], 8'h00});
          exp_reads++;
        end
      end
  endfunction

  // Predicted cfg_done time: each transaction costs issue + slave latency +
  // synchronizer/edge latency + gap; each non-final NEXT step adds one cycle.
  function automatic int expected_done_time();
    return PWRUP_DLY + exp_q.size() * (lat + GAP_DLY + 4) + (N_REGS * N_CHIPS - 1);
  endfunction

  task automatic clear_mem();
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 256; a++) mem[c][a] = 8'h00;
  endtask

  task automatic randomize_table();
    for (int i = 0; i < N_REGS; i++) reg_val[i] = 8'($urandom);
    lat = int'($urandom_range(2, 8));
  endtask

  task automatic do_reset();
    rstb = 1'b0;
    cfg_restart = 1'b0;
    host_req = 1'b0;
    repeat (3) @(negedge clk);
    obs_q.delete();
    rstb = 1'b1;
    t0 = cyc;
  endtask

  task automatic test_reset();
    #1 rstb = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (spi_start !== 1'b0) begin errors++; $display("FAIL rst_spi_start got=%b exp=0", spi_start); end
    checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL rst_host_ack got=%b exp=0", host_ack); end
    checks++; if (host_done !== 1'b0) begin errors++; $display("FAIL rst_host_done got=%b exp=0", host_done); end
    checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL rst_cfg_done got=%b exp=0", cfg_done); end
    checks++; if (cfg_err !== 2'd0) begin errors++; $display("FAIL rst_cfg_err got=%0d exp=0", cfg_err); end
    checks++; if (err_addr !== 13'h0) begin errors++; $display("FAIL rst_err_addr got=%h exp=0", err_addr); end
    checks++; if (table_addr !== 8'h0) begin errors++; $display("FAIL rst_table_addr got=%h exp=0", table_addr); end
    checks++; if (chip_sel !== 1'b0) begin errors++; $display("FAIL rst_chip_sel got=%b exp=0", chip_sel); end
    checks++; if (host_rdata !== 8'h0) begin errors++; $display("FAIL rst_host_rdata got=%h exp=0", host_rdata); end
    checks++; if (spi_tdat !== 24'hFFFFFF) begin errors++; $display("FAIL rst_spi_tdat got=%h exp=ffffff", spi_tdat); end
    checks++; if (cfg_busy !== 1'b1) begin errors++; $display("FAIL rst_cfg_busy got=%b exp=1", cfg_busy); end
  endtask

  task automatic test_config_ok();
    int t;
    int nrd;
    stall_all = 1'b0; bad14 = 1'b0;
    randomize_table();
    clear_mem();
    build_expected();
    do_reset();
    for (int i = 0; i < 3000 && !cfg_done; i++) @(negedge clk);
    t = cyc - t0;
    checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL cfg_ok_done got=%b exp=1", cfg_done); end
    checks++;
    if (t < expected_done_time() - 2 || t > expected_done_time() + 2) begin
      errors++; $display("FAIL cfg_ok_time got=%0d exp=%0d", t, expected_done_time());
    end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL cfg_ok_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL cfg_ok_xact%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    nrd = 0;
    foreach (obs_q[i]) if (obs_q[i][23]) nrd++;
    checks++; if (nrd != exp_reads) begin errors++; $display("FAIL cfg_ok_reads got=%0d exp=%0d", nrd, exp_reads); end
    checks++; if (cfg_err !== 2'd0) begin errors++; $display("FAIL cfg_ok_err got=%0d exp=0", cfg_err); end
    checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL cfg_ok_busy got=%b exp=0", cfg_busy); end
  endtask

  task automatic test_host();
    int a0;
    logic [7:0] ra;
    logic [7:0] rd;
    logic [23:0] words [3];
    logic [7:0]  exp_rd [3];
    mem[1][8'h01] = 8'h92;
    ra = 8'($urandom_range(8'h40, 8'h7F));
    rd = 8'($urandom);
    words[0] = 24'h800100;                      exp_rd[0] = 8'h92;
    words[1] = {3'b000, 5'b00000, ra, rd};      exp_rd[1] = 8'h00;
    words[2] = {3'b100, 5'b00000, ra, 8'h00};   exp_rd[2] = rd;
    for (int k = 0; k < 3; k++) begin
      a0 = n_ack;
      obs_q.delete();
      host_tdat = words[k];
      host_req = 1'b1;
      for (int i = 0; i < 200 && !host_ack; i++) @(negedge clk);
      host_req = 1'b0;
      checks++; if (host_ack !== 1'b1) begin errors++; $display("FAIL host%0d_ack got=%b exp=1", k, host_ack); end
      for (int i = 0; i < 200 && !host_done; i++) @(negedge clk);
      checks++; if (host_done !== 1'b1) begin errors++; $display("FAIL host%0d_done got=%b exp=1", k, host_done); end
      checks++; if (n_ack - a0 != 1) begin errors++; $display("FAIL host%0d_ack_count got=%0d exp=1", k, n_ack - a0); end
      checks++;
      if (obs_q.size() != 1 || obs_q[0] !== {1'b1, words[k]}) begin
        errors++; $display("FAIL host%0d_word got=%0d xacts exp=one %h on ADC2", k, obs_q.size(), words[k]);
      end
      if (words[k][23]) begin
        checks++; if (host_rdata !== exp_rd[k]) begin errors++; $display("FAIL host%0d_rdata got=%h exp=%h", k, host_rdata, exp_rd[k]); end
      end
    end
  endtask

  task automatic test_restart_race();
    int a0;
    int t;
    repeat (GAP_DLY + 2) @(negedge clk);
    randomize_table();
    build_expected();
    a0 = n_ack;
    cfg_restart = 1'b1; host_req = 1'b1; host_tdat = 24'h800100;
    @(negedge clk);
    cfg_restart = 1'b0; host_req = 1'b0;
    obs_q.delete();
    t0 = cyc;
    repeat (4) @(negedge clk);
    checks++; if (n_ack != a0) begin errors++; $display("FAIL race_ack got=%0d exp=0", n_ack - a0); end
    checks++; if (cfg_busy !== 1'b1) begin errors++; $display("FAIL race_busy got=%b exp=1", cfg_busy); end
    checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL race_done_cleared got=%b exp=0", cfg_done); end
    for (int i = 0; i < 3000 && !cfg_done; i++) @(negedge clk);
    t = cyc - t0;
    checks++;
    if (cfg_done !== 1'b1 || t < expected_done_time() - 2 || t > expected_done_time() + 2) begin
      errors++; $display("FAIL race_redo_time got=%0d done=%b exp=%0d", t, cfg_done, expected_done_time());
    end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL race_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL race_xact%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int t;
    randomize_table();
    build_expected();
    do_reset();
    for (int i = 0; i < 1000 && !(spi_start && spi_tdat[23]); i++) @(negedge clk);
    checks++; if (!(spi_start && spi_tdat[23])) begin errors++; $display("FAIL mid_read_seen got=%b exp=1", spi_start); end
    @(negedge clk);
    rstb = 1'b0;
    #1;
    checks++; if (spi_tdat !== 24'hFFFFFF) begin errors++; $display("FAIL mid_spi_tdat got=%h exp=ffffff", spi_tdat); end
    checks++; if (cfg_busy !== 1'b1 || cfg_done !== 1'b0) begin errors++; $display("FAIL mid_busy_done got=%b%b exp=10", cfg_busy, cfg_done); end
    checks++; if (table_addr !== 8'h0 || chip_sel !== 1'b0) begin errors++; $display("FAIL mid_addr_sel got=%h/%b exp=0/0", table_addr, chip_sel); end
    @(negedge clk);
    obs_q.delete();
    rstb = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 500 && !spi_start; i++) @(negedge clk);
    t = cyc - t0;
    checks++; if (spi_start !== 1'b1 || t != PWRUP_DLY) begin errors++; $display("FAIL mid_pwrup_delay got=%0d exp=%0d", t, PWRUP_DLY); end
    checks++; if ({chip_sel, spi_tdat} !== exp_q[0]) begin errors++; $display("FAIL mid_first_word got=%h exp=%h", {chip_sel, spi_tdat}, exp_q[0]); end
  endtask

  task automatic test_verify_fail();
    logic [24:0] want [$];
    randomize_table();
    reg_val[1] = 8'h20;
    bad14 = 1'b1;
    clear_mem();
    want.push_back({1'b0, 3'b000, reg_addr[0], reg_val[0]});
    want.push_back({1'b0, 3'b100, reg_addr[0], 8'h00});
    for (int r = 0; r <= MAX_RETRY; r++) begin
      want.push_back({1'b0, 24'h001420});
      want.push_back({1'b0, 3'b100, 13'h014, 8'h00});
    end
    do_reset();
    for (int i = 0; i < 3000 && cfg_err == 2'd0; i++) @(negedge clk);
    repeat (100) @(negedge clk);
    checks++; if (cfg_err !== 2'd1) begin errors++; $display("FAIL vfy_err got=%0d exp=1", cfg_err); end
    checks++; if (err_addr !== 13'h014) begin errors++; $display("FAIL vfy_err_addr got=%h exp=014", err_addr); end
    checks++; if (chip_sel !== 1'b0) begin errors++; $display("FAIL vfy_chip_sel got=%b exp=0", chip_sel); end
    checks++; if (cfg_done !== 1'b0 || cfg_busy !== 1'b0) begin errors++; $display("FAIL vfy_done_busy got=%b%b exp=00", cfg_done, cfg_busy); end
    checks++; if (obs_q.size() != want.size()) begin errors++; $display("FAIL vfy_count got=%0d exp=%0d", obs_q.size(), want.size()); end
    for (int i = 0; i < want.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== want[i]) begin errors++; $display("FAIL vfy_xact%0d got=%h exp=%h", i, obs_q[i], want[i]); end
    end
    bad14 = 1'b0;
  endtask

  task automatic test_timeout();
    int ts;
    randomize_table();
    stall_all = 1'b1;
    do_reset();
    for (int i = 0; i < 500 && !spi_start; i++) @(negedge clk);
    ts = cyc;
    for (int i = 0; i < 500 && cfg_err == 2'd0; i++) @(negedge clk);
    checks++; if (cfg_err !== 2'd2) begin errors++; $display("FAIL tmo_err got=%0d exp=2", cfg_err); end
    checks++; if (cyc - ts != DONE_TMO) begin errors++; $display("FAIL tmo_time got=%0d exp=%0d", cyc - ts, DONE_TMO); end
    repeat (300) @(negedge clk);
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL tmo_no_more_start got=%0d exp=1", obs_q.size()); end
    checks++; if (cfg_busy !== 1'b0 || cfg_done !== 1'b0) begin errors++; $display("FAIL tmo_busy_done got=%b%b exp=00", cfg_busy, cfg_done); end
    stall_all = 1'b0;
  endtask

  initial begin
    reg_addr[0] = 13'h005;
    reg_addr[1] = 13'h014;
    reg_addr[2] = 13'h0FF;
    for (int i = 0; i < N_REGS; i++) reg_val[i] = 8'h00;
    clear_mem();
    test_reset();
    test_config_ok();
    test_host();
    test_restart_race();
    test_reset_mid();
    test_verify_fail();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
